// File: rtl/io_input_debounce.sv
// Two-flop synchronizer plus per-bit stability counters for board switches and keys.
// Define IO_DEBOUNCE_SW_EN to debounce switches too; otherwise they are only synchronized.
module io_input_debounce #(
    parameter int NUM_SW          = 10,
    parameter int NUM_KEY         = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_SW-1:0]  i_sw_raw,
    input  logic [NUM_KEY-1:0] i_key_raw,
    output logic [31:0]        o_io_sw,
    output logic [31:0]        o_io_key,
    output logic [NUM_KEY-1:0] o_key_press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEY-1:0] key_s1_q, key_s1_d;
    logic [NUM_KEY-1:0] key_s2_q, key_s2_d;
    logic [NUM_KEY-1:0] key_stable_q, key_stable_d;
    logic [NUM_KEY-1:0] key_press_q, key_press_d;
    logic [CNT_W-1:0]   key_cnt_q [NUM_KEY];
    logic [CNT_W-1:0]   key_cnt_d [NUM_KEY];

    logic [NUM_SW-1:0]  sw_s1_q, sw_s1_d;
    logic [NUM_SW-1:0]  sw_s2_q, sw_s2_d;

    // Any sample matching the accepted level restarts that bit's count.
    always_comb begin
        key_s1_d     = i_key_raw;
        key_s2_d     = key_s1_q;
        key_stable_d = key_stable_q;
        for (int i = 0; i < NUM_KEY; i++) begin
            key_cnt_d[i] = key_cnt_q[i];
            if (key_s2_q[i] == key_stable_q[i]) begin
                key_cnt_d[i] = '0;
            end else if (key_cnt_q[i] == CNT_MAX) begin
                key_stable_d[i] = key_s2_q[i];
                key_cnt_d[i]    = '0;
            end else begin
                key_cnt_d[i] = key_cnt_q[i] + CNT_W'(1);
            end
        end
        key_press_d = key_stable_q & ~key_stable_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            key_s1_q     <= '1;
            key_s2_q     <= '1;
            key_stable_q <= '1;
            key_press_q  <= '0;
            for (int i = 0; i < NUM_KEY; i++) begin
                key_cnt_q[i] <= '0;
            end
        end else begin
            key_s1_q     <= key_s1_d;
            key_s2_q     <= key_s2_d;
            key_stable_q <= key_stable_d;
            key_press_q  <= key_press_d;
            for (int i = 0; i < NUM_KEY; i++) begin
                key_cnt_q[i] <= key_cnt_d[i];
            end
        end
    end

    always_comb begin
        sw_s1_d = i_sw_raw;
        sw_s2_d = sw_s1_q;
    end

`ifdef IO_DEBOUNCE_SW_EN
    logic [NUM_SW-1:0] sw_stable_q, sw_stable_d;
    logic [CNT_W-1:0]  sw_cnt_q [NUM_SW];
    logic [CNT_W-1:0]  sw_cnt_d [NUM_SW];

    always_comb begin
        sw_stable_d = sw_stable_q;
        for (int i = 0; i < NUM_SW; i++) begin
            sw_cnt_d[i] = sw_cnt_q[i];
            if (sw_s2_q[i] == sw_stable_q[i]) begin
                sw_cnt_d[i] = '0;
            end else if (sw_cnt_q[i] == CNT_MAX) begin
                sw_stable_d[i] = sw_s2_q[i];
                sw_cnt_d[i]    = '0;
            end else begin
                sw_cnt_d[i] = sw_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            sw_stable_q <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                sw_cnt_q[i] <= '0;
            end
        end else begin
            sw_s1_q     <= sw_s1_d;
            sw_s2_q     <= sw_s2_d;
            sw_stable_q <= sw_stable_d;
            for (int i = 0; i < NUM_SW; i++) begin
                sw_cnt_q[i] <= sw_cnt_d[i];
            end
        end
    end

    assign o_io_sw = 32'(sw_stable_q);
`else
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= sw_s1_d;
            sw_s2_q <= sw_s2_d;
        end
    end

    // Without debouncing the second synchronizer stage is the output register.
    assign o_io_sw = 32'(sw_s2_q);
`endif

    assign o_io_key    = 32'(key_stable_q);
    assign o_key_press = key_press_q;

endmodule

// File: tb/tb_io_input_debounce.sv
// Bench for io_input_debounce with DEBOUNCE_CYCLES=8: vector table plus switch sequences.
// Switch expectations follow IO_DEBOUNCE_SW_EN as compiled into the design.
module tb_io_input_debounce;

`ifdef IO_DEBOUNCE_SW_EN
    localparam bit SW_DEB = 1'b1;
`else
    localparam bit SW_DEB = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic [9:0]  sw;
        logic [2:0]  key;
        int          cyc;
        logic [31:0] exp_sw;
        logic [31:0] exp_key;
        logic [2:0]  exp_press;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [9:0]  sw_raw;
    logic [2:0]  key_raw;
    logic [31:0] io_sw;
    logic [31:0] io_key;
    logic [2:0]  key_press;

    int n_cmp = 0;
    int n_fail = 0;
    int press_cnt [3] = '{0, 0, 0};

    vec_t       vecs[$];
    vec_t       exp_q[$];
    logic [9:0] sw_hist[$];

    io_input_debounce #(
        .NUM_SW(10),
        .NUM_KEY(3),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_sw_raw(sw_raw),
        .i_key_raw(key_raw),
        .o_io_sw(io_sw),
        .o_io_key(io_key),
        .o_key_press(key_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every cycle a press pulse is visible, so stray or doubled pulses show up.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (key_press[i] === 1'b1) press_cnt[i]++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] bench did not complete");
    end

    task automatic compareValue(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic addVec(input logic rst, input logic [9:0] sw, input logic [2:0] key, input int cyc,
                          input logic [31:0] sw_def, input logic [31:0] sw_undef,
                          input logic [31:0] exp_key, input logic [2:0] exp_press);
        vec_t v;
        v.rst       = rst;
        v.sw        = sw;
        v.key       = key;
        v.cyc       = cyc;
        v.exp_sw    = SW_DEB ? sw_def : sw_undef;
        v.exp_key   = exp_key;
        v.exp_press = exp_press;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input int idx);
        vec_t e;
        e = exp_q.pop_front();
        compareValue($sformatf("vec%0d o_io_sw", idx), io_sw, e.exp_sw);
        compareValue($sformatf("vec%0d o_io_key", idx), io_key, e.exp_key);
        compareValue($sformatf("vec%0d o_key_press", idx), {29'b0, key_press}, {29'b0, e.exp_press});
    endtask

    // Called at a falling edge: drive, run the given number of rising edges, sample at the next falling edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        reset   = v.rst;
        sw_raw  = v.sw;
        key_raw = v.key;
        exp_q.push_back(v);
        repeat (v.cyc) @(posedge clk);
        @(negedge clk);
        checkOutput(idx);
    endtask

    // Without debouncing the output lags the driven value by one sample slot.
    task automatic applySwCycle(input logic [9:0] v, input logic [9:0] exp_def, input string name);
        logic [9:0] prev;
        sw_raw = v;
        sw_hist.push_back(v);
        @(posedge clk);
        @(negedge clk);
        prev = sw_hist.pop_front();
        compareValue(name, io_sw, SW_DEB ? {22'b0, exp_def} : {22'b0, prev});
    endtask

    initial begin
        reset   = 1'b1;
        sw_raw  = 10'h3FF;
        key_raw = 3'b010;

        // rst, sw, key, cycles, sw(debounced), sw(sync only), key, press
        for (int i = 0; i < 3; i++) addVec(1, 10'h3FF, 3'b010, 1, 0, 0, 32'h7, 3'b000);
        addVec(0, 10'h000, 3'b111, 12, 0, 0, 32'h7, 3'b000);
        addVec(0, 10'h000, 3'b110,  9, 0, 0, 32'h7, 3'b000);
        addVec(0, 10'h000, 3'b110,  1, 0, 0, 32'h6, 3'b001);
        addVec(0, 10'h000, 3'b110,  1, 0, 0, 32'h6, 3'b000);
        addVec(0, 10'h000, 3'b110,  4, 0, 0, 32'h6, 3'b000);
        addVec(0, 10'h000, 3'b111,  9, 0, 0, 32'h6, 3'b000);
        addVec(0, 10'h000, 3'b111,  1, 0, 0, 32'h7, 3'b000);
        addVec(0, 10'h000, 3'b111,  3, 0, 0, 32'h7, 3'b000);
        addVec(0, 10'h000, 3'b110,  7, 0, 0, 32'h7, 3'b000);
        addVec(0, 10'h000, 3'b111, 12, 0, 0, 32'h7, 3'b000);
        addVec(0, 10'h000, 3'b001,  9, 0, 0, 32'h7, 3'b000);
        addVec(0, 10'h000, 3'b001,  1, 0, 0, 32'h1, 3'b110);
        addVec(0, 10'h000, 3'b001,  1, 0, 0, 32'h1, 3'b000);
        addVec(0, 10'h000, 3'b111, 12, 0, 0, 32'h7, 3'b000);
        addVec(0, 10'h001, 3'b111,  7, 0, 1, 32'h7, 3'b000);
        addVec(1, 10'h001, 3'b111,  1, 0, 0, 32'h7, 3'b000);
        addVec(0, 10'h001, 3'b111,  9, 0, 1, 32'h7, 3'b000);
        addVec(0, 10'h001, 3'b111,  1, 1, 1, 32'h7, 3'b000);
        addVec(0, 10'h000, 3'b111, 12, 0, 0, 32'h7, 3'b000);
        addVec(1, 10'h000, 3'b110,  2, 0, 0, 32'h7, 3'b000);
        addVec(0, 10'h000, 3'b110,  9, 0, 0, 32'h7, 3'b000);
        addVec(0, 10'h000, 3'b110,  1, 0, 0, 32'h6, 3'b001);
        addVec(0, 10'h000, 3'b110,  1, 0, 0, 32'h6, 3'b000);
        addVec(0, 10'h000, 3'b111, 12, 0, 0, 32'h7, 3'b000);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        // Bounce on sw[3] every 3 cycles, then hold high; the level settles at loop cycle 39.
        sw_hist.delete();
        sw_hist.push_back(10'h000);
        for (int c = 0; c < 56; c++) begin
            logic [9:0] v;
            v = (c < 40 && ((c / 3) % 2) == 0) ? 10'h000 : 10'h008;
            applySwCycle(v, (c >= 48) ? 10'h008 : 10'h000, $sformatf("bounce c%0d", c));
        end

        // One-cycle glitch on sw[9], then a held step.
        applySwCycle(10'h208, 10'h008, "sw9 glitch c0");
        for (int c = 1; c < 5; c++) applySwCycle(10'h008, 10'h008, $sformatf("sw9 glitch c%0d", c));
        for (int c = 0; c < 12; c++) begin
            applySwCycle(10'h208, (c >= 9) ? 10'h208 : 10'h008, $sformatf("sw9 step c%0d", c));
        end

        compareValue("press pulses key0", press_cnt[0], 2);
        compareValue("press pulses key1", press_cnt[1], 1);
        compareValue("press pulses key2", press_cnt[2], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/io_input_debounce.md
# io_input_debounce

Input conditioning stage upstream of the single-cycle core's `i_io_sw` / `i_io_key` ports. It synchronizes the raw board switches and push-buttons into the core clock domain and debounces them with per-bit stability counters. It presents zero-extended 32-bit words that the core reads as memory-mapped inputs, plus one-cycle key-press pulses. It runs on the divided 25 MHz core clock.

## Interface
Parameters:
- `NUM_SW`, default 10: number of slide switches.
- `NUM_KEY`, default 3: number of push-buttons; the reset key is not routed here.
- `DEBOUNCE_CYCLES`, default 250000: stable cycles required before a level is accepted (10 ms at 25 MHz). Must be ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: counter width.

Ports:
- `i_clk` in 1: core clock; one clock domain only.
- `i_reset` in 1: reset, synchronous and active-high.
- `i_sw_raw` in NUM_SW: asynchronous raw switch levels, 1 = up.
- `i_key_raw` in NUM_KEY: asynchronous raw key levels, board polarity, 0 = pressed.
- `o_io_sw` out 32: debounced switches in bits [NUM_SW-1:0]; upper bits 0.
- `o_io_key` out 32: debounced keys in bits [NUM_KEY-1:0], board polarity; upper bits 0.
- `o_key_press` out NUM_KEY: one-cycle pulse per key on an accepted press (1→0).

## Operation
- Each input bit passes through two flops, `s1` then `s2`, before any other logic sees it.
- Each debounced bit has its own counter and a `stable` register.
- On each clock edge, per bit:
  - `s2 == stable`: counter ← 0.
  - `s2 != stable` and counter < DEBOUNCE_CYCLES-1: counter ← counter+1.
  - `s2 != stable` and counter == DEBOUNCE_CYCLES-1: `stable` ← `s2`, counter ← 0.
- A glitch shorter than DEBOUNCE_CYCLES cycles, measured at `s2`, never reaches `stable`. Any sample of `s2` equal to `stable` restarts the count.
- `o_key_press[i]` is registered. It is 1 for exactly one cycle, on the same edge where `stable_key[i]` goes 1→0. Releases (0→1) produce no pulse.
- Bits are fully independent. Simultaneous changes on several bits each complete on their own schedule.
- Counter never wraps; the maximum value held is DEBOUNCE_CYCLES-1.

## Timing
- Reset values, applied on any edge with `i_reset`=1, including mid-count:
  - `s1`, `s2`, `stable` for switches: 0.
  - `s1`, `s2`, `stable` for keys: 1 (released).
  - All counters: 0.
  - `o_io_sw` = 0, `o_io_key` = 32'h0000_0000 | {NUM_KEY{1'b1}}, `o_key_press` = 0.
- Reset dominates all other updates in the same cycle.
- Latency: suppose a raw level is first captured into `s1` at edge N and then held. `stable` and the outputs change at edge N+DEBOUNCE_CYCLES+1. Any press pulse occupies the cycle after that edge.
- Outputs are registers (`stable`, pulse flop) with no combinational path from inputs.
- Keys held pressed through reset deassertion are accepted after the normal latency and do generate one press pulse.

## Configuration
- `IO_DEBOUNCE_SW_EN`:
  - Defined: switches use the full synchronizer + counter path described above.
  - Undefined: switch counters are not built. `o_io_sw` bits equal `s2` directly, with latency edge N+1 and reset value 0.
- Keys are always debounced.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8 and `IO_DEBOUNCE_SW_EN` defined unless noted.
- Reset: hold `i_reset`=1 for 3 cycles with `i_key_raw`=3'b010 and `i_sw_raw`=10'h3FF. Every cycle shows `o_io_sw`=0, `o_io_key`=32'h7, `o_key_press`=0.
- Clean press: drive `i_key_raw[0]` 1→0, captured at edge N. `o_io_key` goes 7→6 at edge N+9. `o_key_press`=3'b001 for exactly one cycle. Releasing later produces no pulse.
- Bounce rejection: toggle `i_sw_raw[3]` 0/1 every 3 cycles for 40 cycles, then hold 1. `o_io_sw` stays 0 throughout the bounce. It becomes 32'h8 exactly 9 edges after the final capture.
- Reset mid-count: raise `i_sw_raw[0]`, then assert `i_reset` one cycle at count 5. After release, the switch needs a full 8 stable cycles again; `o_io_sw` stays 0 until then.
- Simultaneous: press keys 1 and 2 in the same cycle. `o_key_press`=3'b110 in a single cycle and `o_io_key`=32'h1.
- Macro undefined: a step on `i_sw_raw[9]` captured at edge N gives `o_io_sw`=32'h200 at edge N+1, and a 1-cycle glitch is passed through.
